router_pkt_ctrl: RTL and testbench

//  Packet-level controller for the 1x3 router. Decodes the header address and sequences

---
 rtl/router_pkt_ctrl.sv | 137 +++++++++++++
 tb/tb_router_pkt_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_ctrl.sv
// Packet controller for the 1x3 router: header decode, FIFO write sequencing
// and a per-port watchdog that soft-resets FIFOs whose output goes unread.
module router_pkt_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] hdr_addr,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] rd_en,
    output logic [2:0] wt_en,
    output logic [2:0] soft_rst,
    output logic [2:0] vld_out,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg
);

    typedef enum logic [2:0] {
        S_DECODE,
        S_WAIT,
        S_LFD,
        S_LD,
        S_FULL,
        S_LAF,
        S_LP,
        S_CPE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_e                  state_q;
    logic [1:0]              addr_q;
    logic [2:0][CNT_W-1:0]   cnt_q;
    logic [2:0]              soft_rst_q;
    logic [2:0]              unread;
    logic                    load;
    logic                    dst_full;

    assign dst_full = fifo_full[addr_q];

    // A soft reset of the port being written abandons the packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_DECODE;
            addr_q  <= 2'd0;
        end else if (state_q != S_DECODE && soft_rst_q[addr_q]) begin
            state_q <= S_DECODE;
        end else begin
            unique case (state_q)
                S_DECODE: begin
                    if (pkt_valid && hdr_addr != 2'd3) begin
                        addr_q  <= hdr_addr;
                        state_q <= fifo_empty[hdr_addr] ? S_LFD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fifo_empty[addr_q])
                        state_q <= S_LFD;
                end
                S_LFD:
                    state_q <= S_LD;
                S_LD: begin
                    if (dst_full)
                        state_q <= S_FULL;
                    else if (!pkt_valid)
                        state_q <= S_LP;
                end
                S_FULL: begin
                    if (!dst_full)
                        state_q <= S_LAF;
                end
                S_LAF: begin
                    if (parity_done)
                        state_q <= S_DECODE;
                    else if (low_pkt_valid)
                        state_q <= S_LP;
                    else
                        state_q <= S_LD;
                end
                S_LP:
                    state_q <= S_CPE;
                S_CPE:
                    state_q <= dst_full ? S_FULL : S_DECODE;
                default:
                    state_q <= S_DECODE;
            endcase
        end
    end

    assign unread = ~fifo_empty & ~rd_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            soft_rst_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!unread[i]) begin
                    cnt_q[i]      <= '0;
                    soft_rst_q[i] <= 1'b0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    cnt_q[i]      <= '0;
                    soft_rst_q[i] <= 1'b1;
                end else begin
                    cnt_q[i]      <= cnt_q[i] + 1'b1;
                    soft_rst_q[i] <= 1'b0;
                end
            end
        end
    end

    assign load = state_q inside {S_LFD, S_LD, S_LAF, S_LP};

    // Shift form keeps wt_en one-hot and never indexes past bit 2.
    assign wt_en = (load && !dst_full) ? (3'b001 << addr_q) : 3'b000;

    assign soft_rst    = soft_rst_q;
    assign vld_out     = ~fifo_empty;
    assign busy        = !(state_q inside {S_DECODE, S_LD});
    assign detect_add  = state_q == S_DECODE;
    assign lfd_state   = state_q == S_LFD;
    assign ld_state    = state_q == S_LD;
    assign laf_state   = state_q == S_LAF;
    assign full_state  = state_q == S_FULL;
    assign rst_int_reg = state_q == S_CPE;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Bench for router_pkt_ctrl: directed packets checked each cycle against a
// packet-phase model, plus literal counts for the key scenarios.
module tb_router_pkt_ctrl;

    localparam int TIMEOUT = 30;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] hdr_addr = 2'd0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] rd_en = 3'b000;
    logic [2:0] wt_en, soft_rst, vld_out;
    logic       busy, detect_add, lfd_state, ld_state;
    logic       laf_state, full_state, rst_int_reg;

    router_pkt_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid),
        .hdr_addr(hdr_addr), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .rd_en(rd_en), .wt_en(wt_en),
        .soft_rst(soft_rst), .vld_out(vld_out), .busy(busy),
        .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Packet-phase model
    localparam int P_DEC = 0, P_WAIT = 1, P_LFD = 2, P_LD = 3;
    localparam int P_FULL = 4, P_LAF = 5, P_LP = 6, P_CPE = 7;

    int       mph = P_DEC;
    int       maddr = 0;
    int       run [3] = '{0, 0, 0};
    bit [2:0] msr = 3'b000;

    function automatic int next_phase();
        bit f;
        f = fifo_full[maddr];
        if (mph != P_DEC && msr[maddr]) return P_DEC;
        case (mph)
            P_DEC:
                if (pkt_valid && hdr_addr != 2'd3)
                    return fifo_empty[hdr_addr] ? P_LFD : P_WAIT;
                else
                    return P_DEC;
            P_WAIT: return fifo_empty[maddr] ? P_LFD : P_WAIT;
            P_LFD:  return P_LD;
            P_LD:   return f ? P_FULL : (!pkt_valid ? P_LP : P_LD);
            P_FULL: return f ? P_FULL : P_LAF;
            P_LAF:
                if (parity_done) return P_DEC;
                else return low_pkt_valid ? P_LP : P_LD;
            P_LP:   return P_CPE;
            default: return f ? P_FULL : P_DEC;
        endcase
    endfunction

    // Watchdog as run length of consecutive unread cycles.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mph   <= P_DEC;
            maddr <= 0;
            run   <= '{0, 0, 0};
            msr   <= 3'b000;
        end else begin
            mph <= next_phase();
            if (mph == P_DEC && pkt_valid && hdr_addr != 2'd3)
                maddr <= int'(hdr_addr);
            for (int i = 0; i < 3; i++) begin
                if (!fifo_empty[i] && !rd_en[i]) begin
                    run[i] <= run[i] + 1;
                    msr[i] <= ((run[i] + 1) % TIMEOUT) == 0;
                end else begin
                    run[i] <= 0;
                    msr[i] <= 1'b0;
                end
            end
        end
    end

    int cnt_wt1 = 0, cnt_ld = 0, cnt_lfd = 0, cnt_rint = 0;
    int cnt_full = 0, cnt_fbusy = 0, cnt_wt_any = 0;

    always @(negedge clk) begin
        logic [2:0] exp_wt;
        logic       exp_busy;
        exp_wt = 3'b000;
        if ((mph == P_LFD || mph == P_LD || mph == P_LAF || mph == P_LP)
            && !fifo_full[maddr])
            exp_wt[maddr] = 1'b1;
        exp_busy = !(mph == P_DEC || mph == P_LD);
        chk("wt_en", {5'd0, wt_en}, {5'd0, exp_wt});
        chk("soft_rst", {5'd0, soft_rst}, {5'd0, msr});
        chk("vld_out", {5'd0, vld_out}, {5'd0, ~fifo_empty});
        chk("busy", {7'd0, busy}, {7'd0, exp_busy});
        chk("strobes",
            {2'd0, detect_add, lfd_state, ld_state,
             laf_state, full_state, rst_int_reg},
            {2'd0, mph == P_DEC, mph == P_LFD, mph == P_LD,
             mph == P_LAF, mph == P_FULL, mph == P_CPE});
        cnt_wt1    <= cnt_wt1 + int'(wt_en[1]);
        cnt_ld     <= cnt_ld + int'(ld_state);
        cnt_lfd    <= cnt_lfd + int'(lfd_state);
        cnt_rint   <= cnt_rint + int'(rst_int_reg);
        cnt_full   <= cnt_full + int'(full_state);
        cnt_fbusy  <= cnt_fbusy + int'(full_state & busy);
        cnt_wt_any <= cnt_wt_any + int'(wt_en != 3'b000);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int b_wt1, b_ld, b_lfd, b_rint, b_full, b_fbusy, b_any;

        tick(2);
        chk("rst_detect", {7'd0, detect_add}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_wt_en", {5'd0, wt_en}, 8'd0);
        chk("rst_soft_rst", {5'd0, soft_rst}, 8'd0);
        rstn = 1'b1;
        tick();

        // Header 0x21, 8 data cycles, parity
        b_wt1 = cnt_wt1; b_ld = cnt_ld; b_lfd = cnt_lfd; b_rint = cnt_rint;
        pkt_valid = 1'b1; hdr_addr = 2'd1;
        tick();
        chk("lfd_state", {7'd0, lfd_state}, 8'd1);
        chk("lfd_wt_en", {5'd0, wt_en}, 8'h02);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) pkt_valid = 1'b0;
            tick();
        end
        tick();
        chk("cpe_rst_int", {7'd0, rst_int_reg}, 8'd1);
        tick();
        chk("cpe_to_decode", {7'd0, detect_add}, 8'd1);
        tick();
        chk("pkt_wt1_pulses", 8'(cnt_wt1 - b_wt1), 8'd10);
        chk("pkt_ld_cycles", 8'(cnt_ld - b_ld), 8'd8);
        chk("pkt_lfd_cycles", 8'(cnt_lfd - b_lfd), 8'd1);
        chk("pkt_cpe_cycles", 8'(cnt_rint - b_rint), 8'd1);

        // Async reset in LOAD_DATA
        pkt_valid = 1'b1; hdr_addr = 2'd1;
        tick(3);
        chk("pre_rst_ld", {7'd0, ld_state}, 8'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_detect", {7'd0, detect_add}, 8'd1);
        chk("arst_wt_en", {5'd0, wt_en}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        tick();
        pkt_valid = 1'b0; rstn = 1'b1;
        tick();

        // Port 2 full for 3 cycles mid-payload
        b_full = cnt_full; b_fbusy = cnt_fbusy;
        pkt_valid = 1'b1; hdr_addr = 2'd2;
        tick(3);
        fifo_full = 3'b100;
        tick(3);
        fifo_full = 3'b000;
        tick();
        chk("laf_state", {7'd0, laf_state}, 8'd1);
        chk("laf_wt_en", {5'd0, wt_en}, 8'h04);
        tick();
        chk("laf_to_ld", {7'd0, ld_state}, 8'd1);
        chk("full_cycles", 8'(cnt_full - b_full), 8'd3);
        chk("full_busy_cycles", 8'(cnt_fbusy - b_fbusy), 8'd3);
        pkt_valid = 1'b0;
        tick(3);

        // Header 0x0C to a non-empty port 0
        fifo_empty = 3'b110;
        pkt_valid = 1'b1; hdr_addr = 2'd0;
        tick();
        chk("wait_busy", {7'd0, busy}, 8'd1);
        chk("wait_no_detect", {7'd0, detect_add}, 8'd0);
        tick(2);
        chk("wait_hold", {7'd0, busy}, 8'd1);
        fifo_empty = 3'b111;
        tick();
        chk("wait_lfd_wt_en", {5'd0, wt_en}, 8'h01);
        pkt_valid = 1'b0;
        tick(4);

        // Header 0x13: address 3 is dropped
        b_any = cnt_wt_any;
        pkt_valid = 1'b1; hdr_addr = 2'd3;
        tick(6);
        chk("drop_detect", {7'd0, detect_add}, 8'd1);
        pkt_valid = 1'b0;
        tick();
        chk("drop_no_wt", 8'(cnt_wt_any - b_any), 8'd0);

        // Port 1 watchdog
        fifo_empty = 3'b101;
        tick(29);
        chk("wd_before", {5'd0, soft_rst}, 8'd0);
        tick();
        chk("wd_pulse", {5'd0, soft_rst}, 8'h02);
        tick();
        chk("wd_one_cycle", {5'd0, soft_rst}, 8'd0);
        fifo_empty = 3'b111;
        tick();
        fifo_empty = 3'b101;
        tick(28);
        rd_en = 3'b010;
        tick();
        rd_en = 3'b000;
        tick(29);
        chk("wd_restart_quiet", {5'd0, soft_rst}, 8'd0);
        tick();
        chk("wd_restart_pulse", {5'd0, soft_rst}, 8'h02);

        // Soft reset of port 1 during a port-1 packet
        fifo_empty = 3'b111;
        tick();
        pkt_valid = 1'b1; hdr_addr = 2'd1;
        tick(2);
        fifo_empty = 3'b101;
        tick(30);
        chk("sr_in_ld", {7'd0, ld_state}, 8'd1);
        chk("sr_pulse", {5'd0, soft_rst}, 8'h02);
        pkt_valid = 1'b0;
        tick();
        chk("sr_to_decode", {7'd0, detect_add}, 8'd1);
        fifo_empty = 3'b111;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
